// File: rtl/l2_bus_controller.sv
// Shared-bus controller: snoop broadcast, HITM writeback wait, memory latency, response.
// Optional BUS_STATS_EN adds saturating hit/hitm/timeout counters on the snoop phase.
module l2_bus_controller #(
    parameter int ADDR_W    = 32,
    parameter int OFFSET_W  = 6,
    parameter int MEM_LAT   = 4,
    parameter int SNOOP_TMO = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              snp_valid,
    output logic [1:0]        snp_op,
    output logic [ADDR_W-1:0] snp_addr,
    input  logic              snp_result_valid,
    input  logic [1:0]        snp_result,
    input  logic              wb_done,
    output logic              mem_busy,
    output logic              mem_we,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_result
`ifdef BUS_STATS_EN
    ,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       hitm_cnt,
    output logic [15:0]       tmo_cnt
`endif
);

    localparam logic [1:0] OP_RD  = 2'd0;
    localparam logic [1:0] OP_WR  = 2'd1;
    localparam logic [1:0] OP_INV = 2'd2;

    localparam logic [1:0] R_NOHIT = 2'd0;
    localparam logic [1:0] R_HIT   = 2'd1;
    localparam logic [1:0] R_HITM  = 2'd2;

    localparam int TW = $clog2(SNOOP_TMO + 1);
    localparam int MW = $clog2(MEM_LAT + 1);
    localparam logic [TW-1:0] TMO_V = TW'(SNOOP_TMO);
    localparam logic [MW-1:0] LAT_V = MW'(MEM_LAT);
    localparam logic [ADDR_W-1:0] LINE_MASK =
        ~ADDR_W'((64'd1 << OFFSET_W) - 64'd1);

    typedef enum logic [2:0] {
        IDLE,
        SNOOP,
        WAIT_WB,
        MEM,
        RESP
    } state_t;

    state_t        state, state_n;
    logic [1:0]    op_q;
    logic [1:0]    result_q, result_n;
    logic [TW-1:0] snp_cnt, snp_cnt_n;
    logic [MW-1:0] mem_cnt, mem_cnt_n;
    logic          accept;
    logic          wr_op;
    logic          tmo_hit;
    logic          snp_done;

    assign req_ready = rst_n && (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign wr_op     = (state == IDLE) ? (req_op == OP_WR) : (op_q == OP_WR);

    // A real peer answer wins over a timeout landing on the same cycle.
    assign tmo_hit  = (state == SNOOP) && !snp_result_valid
                      && (snp_cnt_n == TMO_V);
    assign snp_done = (state == SNOOP) && (snp_result_valid || tmo_hit);

    always_comb begin
        state_n   = state;
        result_n  = result_q;
        snp_cnt_n = '0;
        mem_cnt_n = '0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n  = (req_op == OP_WR) ? MEM : SNOOP;
                    result_n = R_NOHIT;
                end
            end
            SNOOP: begin
                snp_cnt_n = snp_cnt + TW'(1);
                if (snp_result_valid) begin
                    result_n = (snp_result == 2'd3) ? R_NOHIT : snp_result;
                end else if (tmo_hit) begin
                    result_n = R_NOHIT;
                end
                if (snp_done) begin
                    if (result_n == R_HITM) begin
                        state_n = WAIT_WB;
                    end else if (op_q == OP_INV) begin
                        state_n = RESP;
                    end else begin
                        state_n = MEM;
                    end
                end
            end
            WAIT_WB: begin
                if (wb_done) begin
                    state_n = (op_q == OP_INV) ? RESP : MEM;
                end
            end
            MEM: begin
                mem_cnt_n = mem_cnt + MW'(1);
                if (mem_cnt_n == LAT_V) begin
                    state_n = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_q       <= OP_RD;
            result_q   <= R_NOHIT;
            snp_cnt    <= '0;
            mem_cnt    <= '0;
            snp_valid  <= 1'b0;
            snp_op     <= 2'd0;
            snp_addr   <= '0;
            mem_busy   <= 1'b0;
            mem_we     <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= 2'd0;
        end else begin
            state     <= state_n;
            result_q  <= result_n;
            snp_cnt   <= snp_cnt_n;
            mem_cnt   <= mem_cnt_n;
            snp_valid <= accept && (req_op != OP_WR);
            if (accept) begin
                op_q <= req_op;
            end
            if (accept && (req_op != OP_WR)) begin
                snp_op   <= req_op;
                snp_addr <= req_addr & LINE_MASK;
            end
            mem_busy   <= (state_n == MEM);
            mem_we     <= (state_n == MEM) && wr_op;
            rsp_valid  <= (state_n == RESP);
            rsp_result <= (state_n == RESP) ? result_n : R_NOHIT;
        end
    end

`ifdef BUS_STATS_EN
    logic hit_inc, hitm_inc;

    assign hit_inc  = snp_done && !tmo_hit && (result_n == R_HIT);
    assign hitm_inc = snp_done && !tmo_hit && (result_n == R_HITM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= 16'd0;
            hitm_cnt <= 16'd0;
            tmo_cnt  <= 16'd0;
        end else begin
            if (hit_inc && (hit_cnt != 16'hFFFF)) begin
                hit_cnt <= hit_cnt + 16'd1;
            end
            if (hitm_inc && (hitm_cnt != 16'hFFFF)) begin
                hitm_cnt <= hitm_cnt + 16'd1;
            end
            if (tmo_hit && (tmo_cnt != 16'hFFFF)) begin
                tmo_cnt <= tmo_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_l2_bus_controller.sv
// Bench for l2_bus_controller: per-transaction timeline model plus latency literals.
module tb_l2_bus_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_addr;
    logic        snp_valid;
    logic [1:0]  snp_op;
    logic [31:0] snp_addr;
    logic        snp_result_valid;
    logic [1:0]  snp_result;
    logic        wb_done;
    logic        mem_busy;
    logic        mem_we;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_result;
`ifdef BUS_STATS_EN
    logic [15:0] hit_cnt, hitm_cnt, tmo_cnt;
`endif

    always #5 clk = ~clk;

    l2_bus_controller dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op(req_op),
        .req_addr(req_addr),
        .snp_valid(snp_valid),
        .snp_op(snp_op),
        .snp_addr(snp_addr),
        .snp_result_valid(snp_result_valid),
        .snp_result(snp_result),
        .wb_done(wb_done),
        .mem_busy(mem_busy),
        .mem_we(mem_we),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_result(rsp_result)
`ifdef BUS_STATS_EN
        ,
        .hit_cnt(hit_cnt),
        .hitm_cnt(hitm_cnt),
        .tmo_cnt(tmo_cnt)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic        chk_on = 1'b0;
    logic        e_ready, e_snp, e_snp_chk, e_busy, e_we, e_rsp, e_stats;
    logic [1:0]  e_snp_op, e_res;
    logic [31:0] e_snp_addr;
    int          cur_t;
    int          first_rsp;
    int          m_hit = 0, m_hitm = 0, m_tmo = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("req_ready", 32'(req_ready), 32'(e_ready));
            check("snp_valid", 32'(snp_valid), 32'(e_snp));
            if (e_snp_chk) begin
                check("snp_op", 32'(snp_op), 32'(e_snp_op));
                check("snp_addr", snp_addr, e_snp_addr);
            end
            check("mem_busy", 32'(mem_busy), 32'(e_busy));
            check("mem_we", 32'(mem_we), 32'(e_we));
            check("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
            if (e_rsp) begin
                check("rsp_result", 32'(rsp_result), 32'(e_res));
            end
`ifdef BUS_STATS_EN
            if (e_stats) begin
                check("hit_cnt", 32'(hit_cnt), 32'(m_hit));
                check("hitm_cnt", 32'(hitm_cnt), 32'(m_hitm));
                check("tmo_cnt", 32'(tmo_cnt), 32'(m_tmo));
            end
`endif
            if (rsp_valid && first_rsp < 0) begin
                first_rsp = cur_t;
            end
        end
    end

    task automatic set_idle_exp(input logic rdy);
        e_ready   = rdy;
        e_snp     = 1'b0;
        e_snp_chk = 1'b0;
        e_busy    = 1'b0;
        e_we      = 1'b0;
        e_rsp     = 1'b0;
        e_res     = 2'd0;
        e_stats   = 1'b1;
    endtask

    // res_cyc: SNOOP cycle (1-based) in which the peer answers, 0 = never.
    // wb_len: WAIT_WB cycle in which wb_done arrives. rdy: rsp_ready delay.
    task automatic run_txn(input logic [1:0] op, input logic [31:0] addr,
                           input int res_cyc, input logic [1:0] res_val,
                           input int wb_len, input int rdy, input bit noise,
                           input int lit_rsp);
        bit wr, got;
        int sl, wl, ml, ms, r, last;
        logic [1:0] eff;
        wr   = (op == 2'd1);
        got  = !wr && res_cyc >= 1 && res_cyc <= 15;
        sl   = wr ? 0 : (got ? res_cyc : 15);
        eff  = got ? ((res_val == 2'd3) ? 2'd0 : res_val) : 2'd0;
        wl   = (!wr && eff == 2'd2) ? wb_len : 0;
        ml   = (op == 2'd2) ? 0 : 4;
        ms   = 1 + sl + wl;
        r    = ms + ml;
        last = r + rdy + 1;
        if (!wr) begin
            if (!got) m_tmo++;
            else if (eff == 2'd1) m_hit++;
            else if (eff == 2'd2) m_hitm++;
        end
        @(posedge clk);
        #1;
        req_valid  = 1'b1;
        req_op     = op;
        req_addr   = addr;
        e_snp_op   = op;
        e_snp_addr = {addr[31:6], 6'd0};
        cur_t      = 0;
        first_rsp  = -1;
        set_idle_exp(1'b1);
        chk_on     = 1'b1;
        for (int t = 1; t <= last; t++) begin
            @(posedge clk);
            #1;
            cur_t = t;
            req_valid = (t < r);
            snp_result_valid = (got && t == res_cyc) || (noise && t > sl + wl);
            snp_result = (got && t == res_cyc) ? res_val : 2'd2;
            wb_done = (wl > 0 && t == sl + wl)
                      || (noise && (t <= sl || t > sl + wl));
            rsp_ready = (t == r + rdy) || (noise && t < r);
            e_ready   = (t == last);
            e_snp     = !wr && t == 1;
            e_snp_chk = !wr && t >= 1 && t <= sl;
            e_busy    = t >= ms && t < ms + ml;
            e_we      = e_busy && wr;
            e_rsp     = t >= r && t <= r + rdy;
            e_res     = eff;
            e_stats   = (t == last);
        end
        @(negedge clk);
        #1;
        req_valid        = 1'b0;
        snp_result_valid = 1'b0;
        wb_done          = 1'b0;
        rsp_ready        = 1'b0;
        check("rsp_latency", 32'(first_rsp), 32'(lit_rsp));
    endtask

    task automatic reset_mid_mem();
        @(posedge clk);
        #1;
        chk_on    = 1'b0;
        req_valid = 1'b1;
        req_op    = 2'd1;
        req_addr  = 32'h0000_0100;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("pre_rst_busy", 32'(mem_busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_snp_valid", 32'(snp_valid), 32'd0);
        check("rst_snp_op", 32'(snp_op), 32'd0);
        check("rst_snp_addr", snp_addr, 32'd0);
        check("rst_mem_busy", 32'(mem_busy), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_result", 32'(rsp_result), 32'd0);
        m_hit = 0;
        m_hitm = 0;
        m_tmo = 0;
`ifdef BUS_STATS_EN
        check("rst_hit_cnt", 32'(hit_cnt), 32'd0);
        check("rst_tmo_cnt", 32'(tmo_cnt), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("post_rst_rsp", 32'(rsp_valid), 32'd0);
            check("post_rst_busy", 32'(mem_busy), 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n            = 1'b0;
        req_valid        = 1'b0;
        req_op           = 2'd0;
        req_addr         = 32'd0;
        snp_result_valid = 1'b0;
        snp_result       = 2'd0;
        wb_done          = 1'b0;
        rsp_ready        = 1'b0;
        cur_t            = 0;
        first_rsp        = -1;
        e_snp_op         = 2'd0;
        e_snp_addr       = 32'd0;
        set_idle_exp(1'b0);
        chk_on = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        e_ready = 1'b1;
        @(negedge clk);

        run_txn(2'd0, 32'h0000_1234, 2, 2'd0, 0, 0, 1'b0, 7);
        run_txn(2'd0, 32'h8000_0010, 15, 2'd1, 0, 3, 1'b0, 20);
`ifdef BUS_STATS_EN
        check("lit_hit_after_tmo_edge", 32'(hit_cnt), 32'd1);
        check("lit_tmo_after_tmo_edge", 32'(tmo_cnt), 32'd0);
`endif
        run_txn(2'd3, 32'h0000_4040, 2, 2'd2, 5, 0, 1'b0, 12);
        run_txn(2'd1, 32'hFFFF_FFC7, 0, 2'd0, 0, 0, 1'b1, 5);
        run_txn(2'd2, 32'h0000_2222, 0, 2'd0, 0, 0, 1'b0, 16);
        run_txn(2'd2, 32'h0000_0ABC, 1, 2'd3, 0, 0, 1'b1, 2);
        run_txn(2'd3, 32'h0000_7777, 4, 2'd1, 0, 1, 1'b0, 9);
        run_txn(2'd2, 32'h0000_9990, 3, 2'd2, 2, 0, 1'b0, 6);
        run_txn(2'd0, 32'hABCD_EF7F, 1, 2'd0, 0, 0, 1'b0, 6);
`ifdef BUS_STATS_EN
        check("lit_hit_total", 32'(hit_cnt), 32'd2);
        check("lit_hitm_total", 32'(hitm_cnt), 32'd2);
        check("lit_tmo_total", 32'(tmo_cnt), 32'd1);
`endif
        reset_mid_mem();
        run_txn(2'd0, 32'h0000_0055, 1, 2'd1, 0, 0, 1'b0, 6);

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/l2_bus_controller.md
Name: l2_bus_controller

Overview:
- Shared-bus controller at the far end of the L2 cache's bus interface.
- Accepts bus operations issued by the L2 (READ, WRITE, INVALIDATE, RFO) and broadcasts a snoop to the peer cache.
- Collects the peer's snoop result (NOHIT/HIT/HITM), waits for a peer writeback on HITM, and models memory latency.
- Returns the combined snoop result to the requesting L2; the L2 uses that result for its MESI fill-state decision.

Parameters:
ADDR_W, 32, address width
OFFSET_W, 6, line offset bits; zeroed on every address sent out
MEM_LAT, 4, memory access cycles (>=1)
SNOOP_TMO, 15, cycles to wait for snp_result_valid before forcing NOHIT (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  L2 bus request valid
req_ready  out  1  controller can accept a request
req_op  in  2  0=READ 1=WRITE(writeback) 2=INVALIDATE 3=RFO
req_addr  in  ADDR_W  request address
snp_valid  out  1  one-cycle snoop broadcast pulse
snp_op  out  2  forwarded op (READ/INVALIDATE/RFO)
snp_addr  out  ADDR_W  line-aligned snoop address
snp_result_valid  in  1  peer result strobe
snp_result  in  2  0=NOHIT 1=HIT 2=HITM 3=reserved
wb_done  in  1  peer writeback of a HITM line complete
mem_busy  out  1  memory access in progress
mem_we  out  1  current memory access is a write
rsp_valid  out  1  response valid, held until accepted
rsp_ready  in  1  L2 accepts response
rsp_result  out  2  combined snoop result returned to L2

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - All registered outputs 0: snp_valid, snp_op, snp_addr, mem_busy, mem_we, rsp_valid, rsp_result.
  - Counters 0. req_ready is 0 while rst_n=0.
- Reset asserted mid-operation aborts the transaction immediately. No response is produced for the aborted request.
- req_ready = 1 only in IDLE. A transfer occurs on a clock edge with req_valid && req_ready.
  - On transfer: latch op, addr with low OFFSET_W bits cleared, and result register = NOHIT.
- IDLE -> MEM if op=WRITE; no snoop is issued, mem_we=1.
- IDLE -> SNOOP for all other ops.
  - snp_valid=1 for exactly the first SNOOP cycle; snp_op and snp_addr hold their values through SNOOP.
- SNOOP: timeout counter increments each cycle.
  - snp_result_valid=1: latch the result (3 is treated as NOHIT).
  - Otherwise, counter reaching SNOOP_TMO: result=NOHIT.
  - snp_result_valid takes priority over timeout in the same cycle.
  - Next state:
    - HITM -> WAIT_WB.
    - Otherwise INVALIDATE -> RESP.
    - Otherwise (READ/RFO) -> MEM with mem_we=0.
- WAIT_WB: wb_done is sampled only in this state; pulses in other states are ignored.
  - On wb_done: INVALIDATE -> RESP, READ/RFO -> MEM.
  - No timeout.
- MEM: mem_busy=1 for exactly MEM_LAT cycles, then -> RESP.
- RESP: rsp_valid=1 with rsp_result = latched result.
  - Holds stable until rsp_ready=1, then -> IDLE.
  - rsp_valid drops the cycle after acceptance.
  - rsp_ready while not in RESP is ignored.
- Latencies:
  - WRITE: MEM_LAT+1 cycles from accept to rsp_valid.
  - READ NOHIT with immediate result: MEM_LAT+2.
- Only one outstanding transaction at a time.

Optional Feature:
BUS_STATS_EN
- Defined: adds output ports hit_cnt[15:0], hitm_cnt[15:0], tmo_cnt[15:0].
  - Each is a saturating counter (holds at 16'hFFFF), incremented on exiting SNOOP with HIT, with HITM, or by timeout respectively.
  - Reset to 0 by rst_n.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset release, req_op=0 addr=32'h0000_1234, peer answers NOHIT the cycle after snp_valid -> snp_addr=32'h0000_1200, snp_valid high 1 cycle, mem_busy 4 cycles, rsp_result=0.
- req_op=3 addr=32'h0000_4040, peer HITM, wb_done 5 cycles later -> stays WAIT_WB until wb_done, then 4 mem cycles, rsp_result=2.
- req_op=1 addr=32'hFFFF_FFC7 -> no snp_valid, mem_we=1, mem_busy 4 cycles, rsp_valid with rsp_result=0, and req_ready low throughout.
- req_op=2, no peer response -> forced NOHIT after 15 cycles; RESP without mem_busy, rsp_result=0.
- snp_result_valid with HIT on the timeout cycle, and rsp_ready held low 3 cycles -> rsp_result=1, rsp_valid stable 4 cycles; with BUS_STATS_EN, hit_cnt=1 and tmo_cnt=0.
- rst_n pulled low during MEM -> all outputs 0 immediately; after release req_ready=1 and no rsp_valid appears.
